// File: rtl/leaf_out_packetizer_pkg.sv
// Shared packet layout for the leaf shell: field widths, credit limits and the packet builder.
package leaf_out_packetizer_pkg;

  localparam int PAYLOAD_BITS  = 32;
  localparam int NUM_LEAF_BITS = 5;
  localparam int NUM_PORT_BITS = 4;
  localparam int NUM_ADDR_BITS = 7;
  localparam int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
  localparam int VLD_BIT       = PACKET_BITS - 1;
  localparam int CREDIT_MAX    = 2 ** NUM_ADDR_BITS;
  localparam int CREDIT_BITS   = NUM_ADDR_BITS + 1;

  typedef logic [PACKET_BITS-1:0] packet_t;

  function automatic packet_t pack_packet(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    return {1'b1, leaf, port, addr, payload};
  endfunction

endpackage

// File: rtl/leaf_out_packetizer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer; pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_nxt;
  end

endmodule

// File: rtl/leaf_out_packetizer.sv
// Output side of a leaf shell: merges user streams into one BFT packet stream with
// per-port destination table, receiver credit tracking, round-robin fairness and resend gating.
module leaf_out_packetizer
  import leaf_out_packetizer_pkg::*;
#(
  parameter int NUM_OUT_PORTS         = 5,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 resend,
  input  logic                                 cfg_vld,
  input  logic [NUM_PORT_BITS-1:0]             cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]             cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]             cfg_dest_port,
  input  logic                                 credit_vld,
  input  logic [NUM_PORT_BITS-1:0]             credit_port,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]             vld_user,
  output logic [NUM_OUT_PORTS-1:0]             ack_user,
  output logic [PACKET_BITS-1:0]               dout_bft,
  input  logic                                 dout_rdy,
  output logic                                 credit_err
);

  localparam int SUM_W = CREDIT_BITS + 2;
  localparam logic [SUM_W-1:0] FS_INC  = SUM_W'(FREESPACE_UPDATE_SIZE);
  localparam logic [SUM_W-1:0] CRD_MAX = SUM_W'(CREDIT_MAX);

  logic [NUM_LEAF_BITS-1:0] dest_leaf_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port_q [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] table_valid_q;
  logic [CREDIT_BITS-1:0]   credit_q    [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_nxt  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_q       [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] overflow;
  packet_t                  out_q;
  logic                     credit_err_q;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] gnt;
  logic                     issue;
  logic [SUM_W-1:0]         sum;
  packet_t                  pkt_nxt;

  // Valid/ready: dout_bft is offered while its MSB is set and leaves on a cycle with
  // dout_rdy=1; a new packet may be loaded in that same cycle.
  assign issue = !resend && (!out_q[VLD_BIT] || dout_rdy);

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      eligible[i] = vld_user[i] && table_valid_q[i] && (credit_q[i] != '0);
  end

  rr_arbiter #(.N(NUM_OUT_PORTS)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (eligible),
    .en    (issue),
    .gnt   (gnt)
  );

  assign ack_user   = gnt;
  assign dout_bft   = resend ? '0 : out_q;
  assign credit_err = credit_err_q;

  always_comb begin
    pkt_nxt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (gnt[i])
        pkt_nxt = pack_packet(dest_leaf_q[i], dest_port_q[i], seq_q[i],
                              din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]);
  end

  // A grant and a freespace update can land on the same port in one cycle.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = SUM_W'(credit_q[i]) - SUM_W'(gnt[i]);
      if (credit_vld && credit_port == NUM_PORT_BITS'(i)) sum = sum + FS_INC;
      overflow[i]   = (sum > CRD_MAX);
      credit_nxt[i] = overflow[i] ? CREDIT_BITS'(CREDIT_MAX) : CREDIT_BITS'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q         <= '0;
      credit_err_q  <= 1'b0;
      table_valid_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_leaf_q[i] <= '0;
        dest_port_q[i] <= '0;
        credit_q[i]    <= CREDIT_BITS'(CREDIT_MAX);
        seq_q[i]       <= '0;
      end
    end else begin
      if (issue) out_q <= pkt_nxt;
      if (|overflow) credit_err_q <= 1'b1;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_nxt[i];
        if (gnt[i]) seq_q[i] <= seq_q[i] + 1'b1;
        if (cfg_vld && cfg_port == NUM_PORT_BITS'(i)) begin
          table_valid_q[i] <= 1'b1;
          dest_leaf_q[i]   <= cfg_dest_leaf;
          dest_port_q[i]   <= cfg_dest_port;
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Bench for leaf_out_packetizer: behavioural model checked every cycle plus directed scenarios.
module tb_leaf_out_packetizer;

  localparam int N  = 5;
  localparam int PB = 32;

  logic          clk = 1'b0;
  logic          reset, resend, cfg_vld, credit_vld, dout_rdy, credit_err;
  logic [3:0]    cfg_port, cfg_dest_port, credit_port;
  logic [4:0]    cfg_dest_leaf;
  logic [N*PB-1:0] din_user;
  logic [N-1:0]  vld_user, ack_user;
  logic [48:0]   dout_bft;

  leaf_out_packetizer #(.NUM_OUT_PORTS(N), .FREESPACE_UPDATE_SIZE(64)) dut (
    .clk(clk), .reset(reset), .resend(resend), .cfg_vld(cfg_vld), .cfg_port(cfg_port),
    .cfg_dest_leaf(cfg_dest_leaf), .cfg_dest_port(cfg_dest_port), .credit_vld(credit_vld),
    .credit_port(credit_port), .din_user(din_user), .vld_user(vld_user), .ack_user(ack_user),
    .dout_bft(dout_bft), .dout_rdy(dout_rdy), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int          m_credit [N];
  int          m_seq    [N];
  logic [4:0]  m_leaf   [N];
  logic [3:0]  m_dport  [N];
  bit          m_tv     [N];
  int          m_rr;
  logic [48:0] m_out;
  bit          m_err;

  logic [48:0] obs_dout;
  logic [N-1:0] obs_ack;
  logic        obs_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_credit[p] = 128; m_seq[p] = 0; m_leaf[p] = '0; m_dport[p] = '0; m_tv[p] = 0;
    end
    m_rr = 0; m_out = '0; m_err = 0;
  endtask

  task automatic idle_inputs();
    reset = 0; resend = 0; cfg_vld = 0; cfg_port = '0; cfg_dest_leaf = '0; cfg_dest_port = '0;
    credit_vld = 0; credit_port = '0; din_user = '0; vld_user = '0; dout_rdy = 1;
  endtask

  // One clock: compare DUT outputs with the model at negedge, then advance the model.
  task automatic cycle();
    int w, p, c;
    logic [48:0] exp_dout;
    logic [N-1:0] exp_ack;
    bit issue;
    @(negedge clk);
    exp_dout = resend ? '0 : m_out;
    issue = !resend && (!m_out[48] || dout_rdy);
    w = -1;
    if (issue)
      for (int k = 0; k < N; k++) begin
        p = (m_rr + k) % N;
        if (w < 0 && vld_user[p] && m_tv[p] && m_credit[p] > 0) w = p;
      end
    exp_ack = (w >= 0) ? N'(1 << w) : '0;
    obs_dout = dout_bft; obs_ack = ack_user; obs_err = credit_err;
    check("dout_bft", 64'(obs_dout), 64'(exp_dout));
    check("ack_user", 64'(obs_ack), 64'(exp_ack));
    check("credit_err", 64'(obs_err), 64'(m_err));
    if (reset) model_reset();
    else begin
      if (issue)
        m_out = (w >= 0) ? {1'b1, m_leaf[w], m_dport[w], 7'(m_seq[w]), din_user[w*PB +: PB]} : '0;
      if (w >= 0) begin
        m_rr = (w + 1) % N;
        m_seq[w] = (m_seq[w] + 1) % 128;
      end
      for (int q = 0; q < N; q++) begin
        c = m_credit[q] - ((q == w) ? 1 : 0);
        if (credit_vld && int'(credit_port) == q) c = c + 64;
        if (c > 128) begin c = 128; m_err = 1; end
        m_credit[q] = c;
      end
      if (cfg_vld && int'(cfg_port) < N) begin
        m_tv[cfg_port] = 1; m_leaf[cfg_port] = cfg_dest_leaf; m_dport[cfg_port] = cfg_dest_port;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1; cycle(); reset = 0;
  endtask

  task automatic cfg_write(input int port, input int leaf, input int dport);
    cfg_vld = 1; cfg_port = 4'(port); cfg_dest_leaf = 5'(leaf); cfg_dest_port = 4'(dport);
    cycle();
    cfg_vld = 0;
  endtask

  task automatic run_count(input int cycles, input int port, output int acks);
    acks = 0;
    for (int k = 0; k < cycles; k++) begin
      cycle();
      if (obs_ack[port]) acks++;
    end
  endtask

  int acks;
  logic [N-1:0] exp_seq [6];
  logic [48:0]  pkt;

  initial begin
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();
    reset = 0;
    cycle();
    check("reset_dout", 64'(obs_dout), 64'd0);
    check("reset_ack", 64'(obs_ack), 64'd0);
    check("reset_err", 64'(obs_err), 64'd0);

    // single packet, latency and field layout
    do_reset();
    cfg_write(0, 3, 2);
    vld_user = 5'b00001; din_user[0 +: PB] = 32'hDEADBEEF;
    cycle();
    check("t1_ack", 64'(obs_ack), 64'h1);
    vld_user = '0;
    cycle();
    pkt = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
    check("t1_dout", 64'(obs_dout), 64'(pkt));

    // round robin over ports 0,2,4
    do_reset();
    cfg_write(0, 1, 1); cfg_write(2, 2, 2); cfg_write(4, 4, 4);
    exp_seq = '{5'b00001, 5'b00100, 5'b10000, 5'b00001, 5'b00100, 5'b10000};
    vld_user = 5'b10101;
    for (int k = 0; k < 6; k++) begin
      din_user = {$urandom, $urandom, $urandom, $urandom, $urandom};
      cycle();
      check("t2_rr_ack", 64'(obs_ack), 64'(exp_seq[k]));
      if (k > 0) check("t2_seq", 64'(obs_dout[38:32]), 64'((k - 1) / 3));
    end
    vld_user = '0;
    cycle();

    // credit exhaustion and one freespace update
    do_reset();
    cfg_write(1, 6, 3);
    vld_user = 5'b00010;
    run_count(140, 1, acks);
    check("t3_first_acks", 64'(acks), 64'd128);
    credit_vld = 1; credit_port = 4'd1;
    cycle();
    credit_vld = 0;
    run_count(80, 1, acks);
    check("t3_second_acks", 64'(acks), 64'd64);
    vld_user = '0;

    // backpressure hold and release
    do_reset();
    cfg_write(0, 1, 1); cfg_write(3, 2, 2);
    vld_user = 5'b01001; din_user[0 +: PB] = 32'hA5A5_0001; din_user[3*PB +: PB] = 32'h5A5A_0003;
    cycle();
    check("t4_first_ack", 64'(obs_ack), 64'h1);
    dout_rdy = 0;
    pkt = {1'b1, 5'd1, 4'd1, 7'd0, 32'hA5A5_0001};
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t4_hold_dout", 64'(obs_dout), 64'(pkt));
      check("t4_hold_ack", 64'(obs_ack), 64'h0);
    end
    dout_rdy = 1;
    cycle();
    check("t4_release_ack", 64'(obs_ack), 64'h8);
    vld_user = '0;
    cycle();

    // resend gating
    do_reset();
    cfg_write(1, 4, 5);
    vld_user = 5'b00010; din_user[PB +: PB] = 32'h1234_5678; dout_rdy = 0;
    cycle();
    resend = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t5_resend_dout", 64'(obs_dout), 64'h0);
      check("t5_resend_ack", 64'(obs_ack), 64'h0);
    end
    resend = 0;
    cycle();
    pkt = {1'b1, 5'd4, 4'd5, 7'd0, 32'h1234_5678};
    check("t5_replay_dout", 64'(obs_dout), 64'(pkt));
    vld_user = '0; dout_rdy = 1;
    cycle();

    // credit saturation and sticky error
    do_reset();
    cfg_write(2, 7, 7);
    vld_user = 5'b00100;
    run_count(28, 2, acks);
    check("t6_pre_acks", 64'(acks), 64'd28);
    vld_user = '0;
    credit_vld = 1; credit_port = 4'd2;
    cycle();
    credit_port = 4'd9;
    cycle();
    check("t6_err_set", 64'(obs_err), 64'h1);
    credit_vld = 0;
    vld_user = 5'b00100;
    run_count(140, 2, acks);
    check("t6_sat_acks", 64'(acks), 64'd128);
    check("t6_err_sticky", 64'(obs_err), 64'h1);
    vld_user = '0;
    do_reset();
    cycle();
    check("t6_err_cleared", 64'(obs_err), 64'h0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset         = ($urandom_range(0, 199) == 0);
      resend        = ($urandom_range(0, 9) == 0);
      cfg_vld       = ($urandom_range(0, 19) == 0);
      cfg_port      = 4'($urandom_range(0, 15));
      cfg_dest_leaf = 5'($urandom);
      cfg_dest_port = 4'($urandom);
      credit_vld    = ($urandom_range(0, 7) == 0);
      credit_port   = 4'($urandom_range(0, 7));
      vld_user      = N'($urandom);
      din_user      = {$urandom, $urandom, $urandom, $urandom, $urandom};
      dout_rdy      = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
